// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: grants one producer at a time for up to BurstLen beats into a shared FIFO.
// Arbitration takes 1 cycle; within a grant, ready/writeEn are combinational and held low while full is high.
module fifo_wr_arbiter #(
   parameter int DataWidth = 64,
   parameter int NumReq    = 4,
   parameter int BurstLen  = 8,
   parameter int IdWidth   = $clog2(NumReq)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NumReq-1:0]             reqValid,
   input  logic [NumReq*DataWidth-1:0]   reqData,
   output logic [NumReq-1:0]             reqReady,
   input  logic                          full,
   output logic                          writeEn,
   output logic [DataWidth-1:0]          writeData,
   output logic [IdWidth-1:0]            grantId,
   output logic                          busy
);

   localparam int CntWidth = $clog2(BurstLen + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t                state, next_state;
   logic [IdWidth-1:0]    grant_idx, next_grant_idx;
   logic [IdWidth-1:0]    last_grant, next_last_grant;
   logic [CntWidth-1:0]   beat_cnt, next_beat_cnt;

   logic [DataWidth-1:0]  slice [NumReq];
   logic [IdWidth-1:0]    pick;
   logic                  found;
   logic                  cur_vld;
   logic                  accept;
   int                    cand;

   for (genvar g = 0; g < NumReq; g++) begin : g_slice
      assign slice[g] = reqData[g*DataWidth +: DataWidth];
   end

   // Scan starts one past the last winner so every producer gets a turn.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      cand  = 0;
      for (int i = 0; i < NumReq; i++) begin
         cand = (int'(last_grant) + 1 + i) % NumReq;
         if (!found && reqValid[cand[IdWidth-1:0]]) begin
            found = 1'b1;
            pick  = cand[IdWidth-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant_idx  <= '0;
         last_grant <= IdWidth'(NumReq - 1);
         beat_cnt   <= '0;
      end else begin
         state      <= next_state;
         grant_idx  <= next_grant_idx;
         last_grant <= next_last_grant;
         beat_cnt   <= next_beat_cnt;
      end
   end

   always_comb begin
      next_state      = state;
      next_grant_idx  = grant_idx;
      next_last_grant = last_grant;
      next_beat_cnt   = beat_cnt;
      reqReady        = '0;
      writeEn         = 1'b0;
      writeData       = slice[0];
      grantId         = '0;
      busy            = 1'b0;
      cur_vld         = reqValid[grant_idx];
      accept          = 1'b0;

      case (state)
         IDLE: begin
            if (found) begin
               next_state     = GRANT;
               next_grant_idx = pick;
               next_beat_cnt  = '0;
            end
         end
         GRANT: begin
            accept              = cur_vld && !full;
            reqReady[grant_idx] = accept;
            writeEn             = accept;
            writeData           = slice[grant_idx];
            grantId             = grant_idx;
            busy                = 1'b1;
            if (accept) begin
               next_beat_cnt = beat_cnt + CntWidth'(1);
            end
            // full alone never releases the grant; only a dropped valid or a finished burst does.
            if (!cur_vld || (accept && beat_cnt == CntWidth'(BurstLen - 1))) begin
               next_state      = IDLE;
               next_last_grant = grant_idx;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a BurstLen=8 instance plus a BurstLen=1 instance for strict rotation.
module tb_fifo_wr_arbiter;

   localparam int DW = 64;
   localparam int NR = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst = 1'b1;
   logic [NR-1:0]      req_valid, req_ready;
   logic [NR*DW-1:0]   req_data;
   logic               full, write_en, busy;
   logic [DW-1:0]      write_data;
   logic [1:0]         grant_id;

   logic [NR-1:0]      v1, r1;
   logic [NR*DW-1:0]   d1;
   logic               full1, we1, busy1;
   logic [DW-1:0]      wd1;
   logic [1:0]         gid1;

   int seq0 [NR];
   int seq1 [NR];
   int n_chk = 0;
   int n_bad = 0;
   int order [3] = '{0, 1, 3};

   fifo_wr_arbiter #(.DataWidth(DW), .NumReq(NR), .BurstLen(8)) u_dut (
      .clk(clk), .rst(rst), .reqValid(req_valid), .reqData(req_data), .reqReady(req_ready),
      .full(full), .writeEn(write_en), .writeData(write_data), .grantId(grant_id), .busy(busy)
   );

   fifo_wr_arbiter #(.DataWidth(DW), .NumReq(NR), .BurstLen(1)) u_b1 (
      .clk(clk), .rst(rst), .reqValid(v1), .reqData(d1), .reqReady(r1),
      .full(full1), .writeEn(we1), .writeData(wd1), .grantId(gid1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] beat(input int p, input int s);
      return (64'(p) << 32) | 64'(s);
   endfunction

   task automatic drive_data();
      for (int i = 0; i < NR; i++) begin
         req_data[i*DW +: DW] = beat(i, seq0[i]);
         d1[i*DW +: DW]       = beat(i, seq1[i]);
      end
   endtask

   // Producers advance their data only after an accepted beat.
   task automatic next_cyc();
      #1;
      for (int i = 0; i < NR; i++) begin
         if (req_ready[i]) seq0[i]++;
         if (r1[i]) seq1[i]++;
      end
      @(negedge clk);
      drive_data();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      v1 = '0;
      full = 1'b0;
      full1 = 1'b0;
      for (int i = 0; i < NR; i++) begin
         seq0[i] = 0;
         seq1[i] = 0;
      end
      drive_data();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      req_valid = '0;
      v1 = '0;
      full = 1'b0;
      full1 = 1'b0;
      req_data = '0;
      d1 = '0;
      @(negedge clk);

      // Single producer 2, three beats.
      do_reset();
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_we", write_en, 0);
      chk("rst_rdy", req_ready, 0);
      seq0[2] = 'hA0;
      drive_data();
      req_valid = 4'b0100;
      #1;
      chk("t1_idle_we", write_en, 0);
      next_cyc();
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t1_busy", busy, 1);
         chk("t1_gid", grant_id, 2);
         chk("t1_we", write_en, 1);
         chk("t1_dat", write_data, beat(2, 'hA0 + k));
         chk("t1_rdy", req_ready, 4'b0100);
         next_cyc();
      end
      req_valid = '0;
      #1;
      chk("t1_drop_we", write_en, 0);
      next_cyc();
      #1;
      chk("t1_end_busy", busy, 0);

      // Round robin over 0,1,3 with full bursts.
      do_reset();
      req_valid = 4'b1011;
      for (int g = 0; g < 6; g++) begin
         for (int ph = 0; ph < 9; ph++) begin
            #1;
            if (ph == 0) begin
               chk("rr_idle_we", write_en, 0);
               chk("rr_idle_busy", busy, 0);
            end else begin
               chk("rr_gid", grant_id, order[g % 3]);
               chk("rr_we", write_en, 1);
               chk("rr_dat", write_data, beat(order[g % 3], (g / 3) * 8 + ph - 1));
            end
            next_cyc();
         end
      end
      req_valid = '0;
      next_cyc();

      // Full backpressure mid-burst on producer 1.
      do_reset();
      req_valid = 4'b0010;
      #1;
      chk("fb_idle_we", write_en, 0);
      next_cyc();
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("fb_we", write_en, 1);
         chk("fb_dat", write_data, beat(1, k));
         next_cyc();
      end
      full = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("fb_stall_we", write_en, 0);
         chk("fb_stall_rdy", req_ready, 0);
         chk("fb_stall_gid", grant_id, 1);
         chk("fb_stall_busy", busy, 1);
         next_cyc();
      end
      full = 1'b0;
      for (int k = 3; k < 8; k++) begin
         #1;
         chk("fb_we", write_en, 1);
         chk("fb_dat", write_data, beat(1, k));
         next_cyc();
      end
      #1;
      chk("fb_end_busy", busy, 0);
      chk("fb_end_we", write_en, 0);
      req_valid = '0;
      next_cyc();

      // Valid drop after 3 beats, then scan starts at 1.
      do_reset();
      req_valid = 4'b0001;
      next_cyc();
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("vd_we", write_en, 1);
         chk("vd_dat", write_data, beat(0, k));
         next_cyc();
      end
      req_valid = '0;
      #1;
      chk("vd_drop_we", write_en, 0);
      next_cyc();
      req_valid = 4'b0011;
      #1;
      chk("vd_idle_busy", busy, 0);
      next_cyc();
      #1;
      chk("vd_next_gid", grant_id, 1);
      chk("vd_next_we", write_en, 1);
      chk("vd_next_dat", write_data, beat(1, 0));
      req_valid = '0;
      next_cyc();
      next_cyc();

      // Reset during producer 3's 4th beat.
      do_reset();
      req_valid = 4'b1000;
      next_cyc();
      for (int k = 0; k < 3; k++) next_cyc();
      rst = 1'b1;
      #1;
      chk("rm_we4", write_en, 1);
      chk("rm_dat4", write_data, beat(3, 3));
      next_cyc();
      rst = 1'b0;
      req_valid = 4'b1111;
      #1;
      chk("rm_we", write_en, 0);
      chk("rm_busy", busy, 0);
      chk("rm_gid", grant_id, 0);
      next_cyc();
      #1;
      chk("rm_next_gid", grant_id, 0);
      chk("rm_next_we", write_en, 1);
      req_valid = '0;
      next_cyc();
      next_cyc();

      // BurstLen=1: strict per-beat rotation, one beat every 2 cycles.
      do_reset();
      v1 = 4'b1111;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (k % 2 == 0) begin
            chk("b1_idle_we", we1, 0);
         end else begin
            chk("b1_gid", gid1, ((k - 1) / 2) % 4);
            chk("b1_we", we1, 1);
            chk("b1_dat", wd1, beat(((k - 1) / 2) % 4, (k - 1) / 8));
         end
         next_cyc();
      end
      v1 = '0;
      next_cyc();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
